// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor update controller.
package bp_pkg;

  localparam int ADDR_W = 32;
  localparam int PC_W   = ADDR_W;
  localparam int TGT_W  = ADDR_W;

  // Controller FSM encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  // One pending predictor update
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [TGT_W-1:0] target;
    logic             taken;
    logic             hit;
  } bp_entry_t;

  localparam int ENTRY_W = $bits(bp_entry_t);

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue: DEPTH-entry FIFO with combinational head read.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  bp_entry_t                wr_data,
  output bp_entry_t                rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bp_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full queue is dropped even if a pop happens the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointer/count; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: queues resolved branches for the
// predictor update port and sequences redirect/flush on a mispredict.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | accepting branches from EX
//   REDIRECT | one-cycle redirect pulse to fetch, flush asserted
//   FLUSH    | flush held for FLUSH_CYC cycles, EX input ignored
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_target,
  input  logic              ex_taken,
  input  logic              ex_pred_hit,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_addr,
  input  logic              bp_ready,
  output logic [31:0]       bp_addr_ex,
  output logic [31:0]       bp_pred_ex,
  output logic              bp_branch,
  output logic              bp_state_write,
  output logic              bp_state_change,
  output logic              stall_ex,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic [15:0]       mispred_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FC_W  = $clog2(FLUSH_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic [15:0]       mcnt_q, mcnt_d;

  logic              pred_t, mispredict, accepted, pop;
  bp_entry_t         wr_entry, head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign pred_t     = ex_pred_hit & ex_pred_taken;
  assign mispredict = ex_valid & ((ex_taken != pred_t) |
                                  (ex_taken & pred_t & (ex_pred_addr != ex_target)));
  assign accepted   = ex_valid & ~fifo_full & (state_q == ST_IDLE);
  assign pop        = bp_ready & ~fifo_empty;

  assign wr_entry.pc     = ex_pc;
  assign wr_entry.target = ex_target;
  assign wr_entry.taken  = ex_taken;
  assign wr_entry.hit    = ex_pred_hit;

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accepted),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign stall_ex        = (fifo_count == CNT_W'(DEPTH));
  assign bp_addr_ex      = head.pc;
  assign bp_pred_ex      = head.target;
  assign bp_branch       = pop & ~head.hit;
  assign bp_state_write  = pop & head.hit;
  assign bp_state_change = pop & head.taken;

  assign redirect    = (state_q == ST_REDIRECT);
  assign flush       = (state_q != ST_IDLE);
  assign redirect_pc = rpc_q;
  assign mispred_cnt = mcnt_q;

  // Redirect/flush sequencing and mispredict bookkeeping
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rpc_d   = rpc_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accepted && mispredict) begin
          state_d = ST_REDIRECT;
          rpc_d   = ex_taken ? ex_target : ex_pc + 32'd4;
          if (mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_FLUSH;
        fcnt_d  = FC_W'(FLUSH_CYC - 1);
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_IDLE;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      rpc_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rpc_q   <= rpc_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomised + directed bench for bp_update_ctrl against a queue-based model.
module tb_bp_update_ctrl;

  localparam int DEPTH     = 4;
  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_taken, ex_pred_hit, ex_pred_taken, bp_ready;
  logic [31:0] ex_pc, ex_target, ex_pred_addr;
  logic [31:0] bp_addr_ex, bp_pred_ex, redirect_pc;
  logic        bp_branch, bp_state_write, bp_state_change;
  logic        stall_ex, redirect, flush;
  logic [15:0] mispred_cnt;

  bp_update_ctrl #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_taken        (ex_taken),
    .ex_pred_hit     (ex_pred_hit),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_addr    (ex_pred_addr),
    .bp_ready        (bp_ready),
    .bp_addr_ex      (bp_addr_ex),
    .bp_pred_ex      (bp_pred_ex),
    .bp_branch       (bp_branch),
    .bp_state_write  (bp_state_write),
    .bp_state_change (bp_state_change),
    .stall_ex        (stall_ex),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending updates, cycles left blocked after a mispredict,
  // last restart address and the saturating mispredict tally.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        hit;
  } ent_t;

  ent_t        mq[$];
  int          blk;
  logic [31:0] m_rpc;
  int unsigned m_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    blk   = 0;
    m_rpc = 32'h0;
    m_cnt = 0;
  endtask

  function automatic bit is_misp();
    bit pt;
    pt = ex_pred_hit && ex_pred_taken;
    return ex_valid && ((ex_taken != pt) || (ex_taken && pt && ex_pred_addr != ex_target));
  endfunction

  task automatic check_outputs();
    bit   pop;
    ent_t h;
    pop = (mq.size() != 0) && bp_ready;
    h   = '{32'h0, 32'h0, 1'b0, 1'b0};
    if (pop) h = mq[0];
    chk("stall_ex",        32'(stall_ex),        32'(mq.size() == DEPTH));
    chk("bp_branch",       32'(bp_branch),       32'(pop && !h.hit));
    chk("bp_state_write",  32'(bp_state_write),  32'(pop && h.hit));
    chk("bp_state_change", 32'(bp_state_change), 32'(pop && h.tk));
    if (pop) begin
      chk("bp_addr_ex", bp_addr_ex, h.pc);
      chk("bp_pred_ex", bp_pred_ex, h.tgt);
    end
    chk("redirect",    32'(redirect),    32'(blk == FLUSH_CYC + 1));
    chk("flush",       32'(flush),       32'(blk > 0));
    chk("redirect_pc", redirect_pc,      m_rpc);
    chk("mispred_cnt", 32'(mispred_cnt), m_cnt);
  endtask

  task automatic model_edge();
    bit acc, mp;
    acc = ex_valid && (mq.size() < DEPTH) && (blk == 0);
    mp  = is_misp();
    if (mq.size() != 0 && bp_ready) void'(mq.pop_front());
    if (acc) mq.push_back('{ex_pc, ex_target, ex_taken, ex_pred_hit});
    if (blk > 0) blk--;
    if (acc && mp) begin
      blk   = FLUSH_CYC + 1;
      m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  // Called from just after a rising edge; checks mid-cycle, models the edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk, input logic hit, input logic pt,
                     input logic [31:0] pa, input logic rdy);
    ex_valid      = v;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_taken      = tk;
    ex_pred_hit   = hit;
    ex_pred_taken = pt;
    ex_pred_addr  = pa;
    bp_ready      = rdy;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Correctly predicted taken branch
    drv(1, 32'h100, 32'h200, 1, 1, 1, 32'h200, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1);                   step();
    step();

    // Miss, not taken
    drv(1, 32'h40, 32'h1234, 0, 0, 0, 32'h0, 1);   step();
    drv(0, 0, 0, 0, 0, 0, 0, 1);                   step();

    // Wrong target; EX keeps presenting mispredicts that must be ignored
    drv(1, 32'h80, 32'h300, 1, 1, 1, 32'h200, 1);  step();
    chk("wrong_tgt_rpc", redirect_pc, 32'h300);
    drv(1, 32'h500, 32'h600, 0, 1, 1, 32'h600, 1);
    repeat (FLUSH_CYC + 1) step();
    chk("wrong_tgt_cnt", 32'(mispred_cnt), 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);                   step();

    // Fill the queue with the port busy, then drain in order
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 1, 1, 1, 32'h2000 + 32'(i * 16), 0);
      step();
    end
    chk("full_stall", 32'(stall_ex), 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) step();

    // Reset in the middle of a flush with two entries pending
    drv(1, 32'h3000, 32'h3100, 1, 1, 1, 32'h3100, 0); step();
    drv(1, 32'h3010, 32'h3200, 0, 1, 1, 32'h3200, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);                      step(); step();
    chk("pre_rst_flush", 32'(flush), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_flush",    32'(flush),       32'd0);
    chk("rst_redirect", 32'(redirect),    32'd0);
    chk("rst_cnt",      32'(mispred_cnt), 32'd0);
    chk("rst_stall",    32'(stall_ex),    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bp_ready = 1'b1;
    step(); step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt, pa;
      tgt = $urandom() & 32'hFFFF_FFFC;
      pa  = ($urandom_range(1) == 0) ? tgt : ($urandom() & 32'hFFFF_FFFC);
      drv(($urandom_range(9) < 7) ? 1'b1 : 1'b0,
          ($urandom() | 32'hFFFF_0000) & 32'hFFFF_FFFC, tgt,
          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), pa,
          ($urandom_range(9) < 6) ? 1'b1 : 1'b0);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (DEPTH + FLUSH_CYC + 2) step();

    // Saturation: preload the tally near the top, then keep mispredicting
    force dut.mcnt_q = 16'hFFFD;
    #1 release dut.mcnt_q;
    m_cnt = 32'hFFFD;
    drv(1, 32'h7000, 32'h7100, 0, 1, 1, 32'h7100, 1);
    repeat (20) step();
    chk("sat_cnt", 32'(mispred_cnt), 32'hFFFF);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL provide parameters: DEPTH, default 4, update-queue entries (power of 2, at least 2); FLUSH_CYC, default 2, flush hold cycles (at least 1).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-003 clk  in  1  clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ex_valid  in  1  resolved branch present in EX this cycle.
REQ-006 ex_pc, ex_target  in  32 each  branch PC; computed target.
REQ-007 ex_taken  in  1  actual outcome.
REQ-008 ex_pred_hit, ex_pred_taken  in  1 each  predictor hit/taken, as carried from IF.
REQ-009 ex_pred_addr  in  32  predicted address, as carried from IF.
REQ-010 bp_ready  in  1  predictor update port free this cycle.
REQ-011 bp_addr_ex, bp_pred_ex  out  32 each  update address; taken target.
REQ-012 bp_branch, bp_state_write, bp_state_change  out  1 each  allocate strobe; state-update strobe; taken flag.
REQ-013 stall_ex  out  1  queue full, EX must hold.
REQ-014 redirect  out  1  one-cycle pulse.
REQ-015 redirect_pc  out  32  fetch restart address.
REQ-016 flush  out  1  kill IF/ID.
REQ-017 mispred_cnt  out  16  saturating mispredict count.

Function
REQ-018 pred_t = ex_pred_hit & ex_pred_taken.
REQ-019 mispredict = ex_valid & ((ex_taken != pred_t) | (ex_taken & pred_t & (ex_pred_addr != ex_target))).
REQ-020 An accepted branch SHALL be enqueued as {ex_pc, ex_target, ex_taken, ex_pred_hit}; accepted = ex_valid & !stall_ex & state IDLE.
REQ-021 stall_ex = (count == DEPTH), combinational from registered count; enqueue on a full queue SHALL NOT occur, even if a pop happens the same cycle.
REQ-022 The queue head SHALL drive bp_* registered-free from the storage; bp_* strobes SHALL be asserted only while count != 0 and bp_ready = 1; pop on that cycle.
REQ-023 Strobe mapping at head: if hit = 0, assert bp_branch (allocate); if hit = 1, assert bp_state_write. Assert bp_state_change = taken in both cases; bp_pred_ex = target; bp_addr_ex = pc.
REQ-024 Latency SHALL be at least 1 cycle from accept to bp_* (no bypass); at most one pop per cycle; simultaneous push and pop leaves count unchanged.
REQ-025 Pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH)+1.
REQ-026 FSM states: IDLE, REDIRECT, FLUSH.
REQ-027 IDLE -> REDIRECT on an accepted mispredict; that branch is still enqueued.
REQ-028 In REDIRECT, redirect = 1 for exactly one cycle, with redirect_pc = ex_taken ? ex_target : ex_pc + 4 (latched at accept, mod 2^32), and flush = 1.
REQ-029 REDIRECT -> FLUSH; flush SHALL be held for FLUSH_CYC cycles via a down-counter, then -> IDLE.
REQ-030 In REDIRECT and FLUSH, ex_valid SHALL be ignored (not enqueued, not counted); queue draining continues.
REQ-031 mispred_cnt SHALL increment on each accepted mispredict and saturate at 16'hFFFF.
REQ-032 A mispredict arriving while stall_ex = 1 SHALL NOT be accepted; it is accepted when EX re-presents it after the stall clears.

Reset
REQ-033 On rst: count, pointers, and mispred_cnt = 0; state = IDLE; all strobes, redirect, and flush = 0; redirect_pc = 0. Queue contents need not be reset.
REQ-034 rst asserted mid-flush or with a non-empty queue SHALL discard all pending work immediately; no strobe in the first cycle after release.

Structure
REQ-035 FSM state encodings SHALL live in the shared package bp_pkg, together with the queue entry field widths and the 32-bit address width constant.
REQ-036 The queue SHALL be a sub-module bp_upd_fifo (DEPTH-parameterised, full/empty/count); the FSM and counters live in bp_update_ctrl.

Verification
REQ-037 Correct prediction: ex_pc=0x100, taken, pred hit/taken, pred_addr=target=0x200, bp_ready=1 -> next cycle bp_state_write=1, state_change=1, addr=0x100; redirect never asserts.
REQ-038 Miss, not taken: ex_pc=0x40, pred_hit=0, taken=0 -> redirect stays 0; next cycle bp_branch=1, bp_pred_ex=target, state_change=0.
REQ-039 Wrong target: ex_pc=0x80, taken, target=0x300, pred_addr=0x200 -> redirect=1 for one cycle with redirect_pc=0x300; flush=1 for 1+FLUSH_CYC=3 cycles; mispred_cnt=1; ex_valid ignored during those 3 cycles.
REQ-040 Full queue: bp_ready=0, 4 branches accepted -> stall_ex=1; a fifth is held and not enqueued; bp_ready=1 -> four strobes on consecutive cycles in FIFO order; stall_ex drops after the first pop.
REQ-041 Reset mid-flush with 2 entries queued -> after release state=IDLE, flush=0, no bp strobes, mispred_cnt=0.
REQ-042 Saturation: preload via 65536 mispredicts -> mispred_cnt stays 0xFFFF.
